// File: rtl/uart_rx_ctrl_pkg.sv
// Shared parameters and state encoding for the UART receive sequencing controller.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package uart_rx_ctrl_pkg;

    localparam int unsigned RX_DATA_WIDTH = `DATA_WIDTH;
    localparam int unsigned RX_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// Oversample tick counter producing the mid-start-bit and mid-bit sample qualifiers.
module rx_bit_timer
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = RX_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic clear_i,
    output logic mid_start_o,
    output logic sample_o
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_TC = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TC = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clear_i) begin
            tick_cnt_d = '0;
        end else if (tick_i) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign mid_start_o = tick_i && (tick_cnt_q == HALF_TC);
    assign sample_o    = tick_i && (tick_cnt_q == FULL_TC);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sample timing and
// registered one-cycle strobes for the shifter, parity and stop checkers.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RX_DATA_WIDTH,
    parameter int unsigned OVERSAMPLE = RX_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_16x,
    input  logic rx_in,
    input  logic parity_en,
    output logic rx_bit,
    output logic shift_en,
    output logic parity_chk_en,
    output logic stop_chk_en,
    output logic frame_done,
    output logic false_start,
    output logic busy
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e     state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic          rx_bit_q, rx_bit_d;
    logic          shift_q, shift_d;
    logic          par_chk_q, par_chk_d;
    logic          stop_q, stop_d;
    logic          done_q, done_d;
    logic          fs_q, fs_d;
    logic          busy_q, busy_d;
    logic          timer_clr;
    logic          mid_start;
    logic          sample;

    rx_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick_16x),
        .clear_i    (timer_clr),
        .mid_start_o(mid_start),
        .sample_o   (sample)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        rx_bit_d  = rx_bit_q;
        shift_d   = 1'b0;
        par_chk_d = 1'b0;
        stop_d    = 1'b0;
        done_d    = 1'b0;
        fs_d      = 1'b0;
        timer_clr = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Holding the timer clear while idle leaves it at zero on the detect tick.
                timer_clr = 1'b1;
                if (tick_16x && !rx_in) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_start) begin
                    timer_clr = 1'b1;
                    if (!rx_in) begin
                        par_d     = parity_en;
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        fs_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    timer_clr = 1'b1;
                    rx_bit_d  = rx_in;
                    shift_d   = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    timer_clr = 1'b1;
                    rx_bit_d  = rx_in;
                    par_chk_d = 1'b1;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    timer_clr = 1'b1;
                    rx_bit_d  = rx_in;
                    stop_d    = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            rx_bit_q  <= 1'b1;
            shift_q   <= 1'b0;
            par_chk_q <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            rx_bit_q  <= rx_bit_d;
            shift_q   <= shift_d;
            par_chk_q <= par_chk_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_bit        = rx_bit_q;
    assign shift_en      = shift_q;
    assign parity_chk_en = par_chk_q;
    assign stop_chk_en   = stop_q;
    assign frame_done    = done_q;
    assign false_start   = fs_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench: the driver models the serial line per tick and queues the
// strobes a mid-bit sampling receiver must emit; a negedge monitor checks them.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int OS = 16;
    localparam int CYCLE_LIMIT = 60000;

    localparam logic [4:0] K_SHIFT = 5'b10000;
    localparam logic [4:0] K_PAR   = 5'b01000;
    localparam logic [4:0] K_STOP  = 5'b00110;
    localparam logic [4:0] K_FS    = 5'b00001;

    logic clk;
    logic rst;
    logic tick_16x;
    logic rx_in;
    logic parity_en;
    logic rx_bit;
    logic shift_en;
    logic parity_chk_en;
    logic stop_chk_en;
    logic frame_done;
    logic false_start;
    logic busy;

    uart_rx_ctrl #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_16x     (tick_16x),
        .rx_in        (rx_in),
        .parity_en    (parity_en),
        .rx_bit       (rx_bit),
        .shift_en     (shift_en),
        .parity_chk_en(parity_chk_en),
        .stop_chk_en  (stop_chk_en),
        .frame_done   (frame_done),
        .false_start  (false_start),
        .busy         (busy)
    );

    typedef struct {
        logic [4:0] kind;
        int         tick;
        logic       bitv;
        logic       chk_bit;
    } ev_t;

    // Output vector order: busy, rx_bit, shift, parity_chk, stop_chk, frame_done, false_start
    typedef struct {
        string      name;
        logic [6:0] mask;
        logic [6:0] exp;
    } pr_t;

    ev_t evq[$];
    pr_t prq[$];

    int g_tick;
    bit stim_done;
    int total;
    int bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_ev(input logic [4:0] kind, input logic bitv, input logic chk);
        ev_t e;
        e.kind    = kind;
        e.tick    = g_tick;
        e.bitv    = bitv;
        e.chk_bit = chk;
        evq.push_back(e);
    endtask

    task automatic push_probe(input string name, input logic [6:0] mask, input logic [6:0] exp);
        pr_t p;
        p.name = name;
        p.mask = mask;
        p.exp  = exp;
        prq.push_back(p);
    endtask

    // One oversample tick spread over 'gap' clock cycles, tick pulse in the last one.
    task automatic drive_tick(input logic line, input int gap);
        for (int i = 1; i < gap; i++) begin
            tick_16x = 1'b0;
            rx_in    = line;
            @(posedge clk);
            #1;
        end
        tick_16x = 1'b1;
        rx_in    = line;
        @(posedge clk);
        #1;
        g_tick++;
        tick_16x = 1'b0;
    endtask

    task automatic idle_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) drive_tick(1'b1, gap);
    endtask

    task automatic do_reset_pulse();
        rst      = 1'b1;
        tick_16x = 1'b0;
        rx_in    = 1'b1;
        @(posedge clk);
        #1;
        push_probe("reset_vals", 7'h7F, 7'b0100000);
        rst = 1'b0;
    endtask

    // Line waveform of one frame in ticks; expected strobes queued at the mid-bit ticks.
    task automatic send_frame(input logic [DW-1:0] data, input logic pe, input int gap,
                              input int abort_off, input bit toggle_pe);
        int   nbits;
        int   total_ticks;
        int   bit_idx;
        logic line;
        logic pbit;
        nbits       = DW + 2 + int'(pe);
        total_ticks = OS * nbits;
        pbit        = ^data;
        parity_en   = pe;
        for (int off = 0; off < total_ticks; off++) begin
            if (off == abort_off) begin
                do_reset_pulse();
                return;
            end
            bit_idx = off / OS;
            if (bit_idx == 0) line = 1'b0;
            else if (bit_idx <= DW) line = data[bit_idx-1];
            else if (pe && bit_idx == DW + 1) line = pbit;
            else line = 1'b1;
            if (off % OS == OS / 2 && bit_idx > 0) begin
                if (bit_idx <= DW) push_ev(K_SHIFT, line, 1'b1);
                else if (pe && bit_idx == DW + 1) push_ev(K_PAR, line, 1'b1);
                else push_ev(K_STOP, line, 1'b1);
            end
            if (toggle_pe && off == 30) parity_en = ~parity_en;
            drive_tick(line, gap);
            if (off == 40) push_probe("busy_mid", 7'b1000000, 7'b1000000);
        end
        push_probe("busy_after", 7'b1011111, 7'b0000000);
    endtask

    task automatic glitch(input int n_low, input int gap);
        for (int off = 0; off < OS; off++) begin
            if (off == OS / 2) push_ev(K_FS, 1'b0, 1'b0);
            drive_tick((off < n_low) ? 1'b0 : 1'b1, gap);
            if (off == OS / 2) push_probe("busy_fs", 7'b1000001, 7'b0000001);
        end
        push_probe("busy_glitch_end", 7'b1000000, 7'b0000000);
    endtask

    initial begin
        logic [DW-1:0] d;
        rst       = 1'b1;
        tick_16x  = 1'b0;
        rx_in     = 1'b1;
        parity_en = 1'b0;
        stim_done = 1'b0;
        g_tick    = 0;
        repeat (3) @(posedge clk);
        #1;
        push_probe("reset_vals", 7'h7F, 7'b0100000);
        rst = 1'b0;
        idle_ticks(4, 1);

        send_frame(8'hA5, 1'b0, 1, -1, 1'b0);
        idle_ticks(3, 1);
        send_frame(8'h3C, 1'b1, 4, -1, 1'b0);
        idle_ticks(3, 2);
        glitch(3, 1);
        idle_ticks(2, 1);
        send_frame(8'h5A, 1'b0, 1, -1, 1'b0);
        send_frame(8'hC3, 1'b0, 1, -1, 1'b0);
        idle_ticks(2, 1);
        d = 8'($urandom) & 8'hF7;
        send_frame(d, 1'b0, 1, OS * 5 + 4, 1'b0);
        idle_ticks(3, 1);
        send_frame(8'h96, 1'b0, 1, -1, 1'b0);
        idle_ticks(2, 1);
        send_frame(8'h0F, 1'b0, 2, -1, 1'b1);
        idle_ticks(2, 1);

        for (int i = 0; i < 8; i++) begin
            int g;
            g = int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, 8)), g);
            send_frame(8'($urandom), 1'($urandom_range(0, 1)), g, -1, 1'b0);
            idle_ticks(int'($urandom_range(0, 5)), g);
        end

        repeat (4) @(posedge clk);
        #1;
        stim_done = 1'b1;
    end

    int   cyc;
    bit   prev_tick;
    int   prev_idx;
    int   mon_tick;
    logic [6:0] obs;
    logic [4:0] strobes;

    initial begin
        cyc       = 0;
        prev_tick = 1'b0;
        prev_idx  = 0;
        mon_tick  = 0;
        total     = 0;
        bad       = 0;
    end

    always @(negedge clk) begin
        ev_t e;
        pr_t p;
        cyc++;
        obs     = {busy, rx_bit, shift_en, parity_chk_en, stop_chk_en, frame_done, false_start};
        strobes = obs[4:0];

        while (prq.size() > 0) begin
            p = prq.pop_front();
            total++;
            if ((obs & p.mask) !== (p.exp & p.mask)) begin
                bad++;
                $display("FAIL %s: got %b want %b (mask %b) cycle %0d", p.name, obs, p.exp, p.mask, cyc);
            end
        end

        while (prev_tick && evq.size() > 0 && evq[0].tick < prev_idx) begin
            e = evq.pop_front();
            total++;
            bad++;
            $display("FAIL missing_strobe: got none want kind %b at tick %0d", e.kind, e.tick);
        end

        if (prev_tick && evq.size() > 0 && evq[0].tick == prev_idx) begin
            e = evq.pop_front();
            total++;
            if (strobes !== e.kind || (e.chk_bit && rx_bit !== e.bitv)) begin
                bad++;
                $display("FAIL strobe_tick%0d: got strobes %b rx_bit %b want %b rx_bit %b",
                         e.tick, strobes, rx_bit, e.kind, e.bitv);
            end
        end else if (strobes !== 5'b00000) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got %b want 00000 cycle %0d", strobes, cyc);
        end

        prev_tick = (tick_16x === 1'b1);
        if (prev_tick) begin
            prev_idx = mon_tick;
            mon_tick++;
        end

        if (stim_done || cyc > CYCLE_LIMIT) begin
            total++;
            if (!stim_done) begin
                bad++;
                $display("FAIL timeout: got cycle %0d want under %0d", cyc, CYCLE_LIMIT);
            end else if (evq.size() != 0 || mon_tick != g_tick) begin
                bad++;
                $display("FAIL drain: got %0d pending events, %0d ticks want 0 pending, %0d ticks",
                         evq.size(), mon_tick, g_tick);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receive path. Tracks the serial line on a 16x oversampling tick, confirms the start bit at mid-bit, and times every subsequent mid-bit sample. It issues one-cycle strobes that drive the serial-to-parallel shifter, the parity checker and the stop-bit checker, and pulses frame completion. It replaces the receiver's ad-hoc sequencing and is instantiated once inside the receiver top, alongside those datapath blocks.

## Interface
- `DATA_WIDTH`, default 8 (taken from `` `DATA_WIDTH ``): data bits per frame.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥4.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick_16x`  in  1  oversample enable, one `clk` wide per tick. May be held high continuously.
- `rx_in`  in  1  serial line, already synchronized to `clk` upstream. Idle high.
- `parity_en`  in  1  frame carries a parity bit. Sampled only at start-bit confirmation.
- `rx_bit`  out  1  most recently sampled line value.
- `shift_en`  out  1  strobe: shifter captures `rx_bit` (data bits, LSB first).
- `parity_chk_en`  out  1  strobe: parity checker evaluates `rx_bit`.
- `stop_chk_en`  out  1  strobe: stop checker evaluates `rx_bit`.
- `frame_done`  out  1  strobe: frame complete, coincident with `stop_chk_en`.
- `false_start`  out  1  strobe: start bit rejected at mid-bit.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Counters:
  - `tick_cnt`, log2(OVERSAMPLE) bits.
  - `bit_cnt`, log2(DATA_WIDTH) bits.
  - Counters advance only on cycles with `tick_16x`=1.
- IDLE: on a tick with `rx_in`=0, go to START and clear `tick_cnt`.
- START: on each tick, increment `tick_cnt` until it equals OVERSAMPLE/2−1.
  - The tick at OVERSAMPLE/2−1 is the mid-bit evaluation.
  - If `rx_in`=0: latch `parity_en`, clear `tick_cnt` and `bit_cnt`, go to DATA.
  - Otherwise: pulse `false_start` and go to IDLE.
- DATA, PARITY and STOP all sample on the tick where `tick_cnt`=OVERSAMPLE−1. That tick sets `rx_bit`←`rx_in` and clears `tick_cnt`. Non-sample ticks increment `tick_cnt`.
- DATA sample: pulse `shift_en` and increment `bit_cnt`.
  - When `bit_cnt`=DATA_WIDTH−1, go to PARITY if the latched `parity_en` is 1, else to STOP.
- PARITY sample: pulse `parity_chk_en`, go to STOP.
- STOP sample: pulse `stop_chk_en` and `frame_done`, go to IDLE.
  - This happens regardless of the line value; framing errors are judged by the stop checker.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A falling edge arriving half a bit later is detected normally.
- `parity_en` changes mid-frame have no effect on the current frame.
- `rx_in` activity during the DATA, PARITY and STOP states is ignored except at sample ticks.

## Timing
- All outputs are registered.
- Reset: state IDLE, counters 0, `rx_bit`=1, all strobes 0, `busy`=0.
- `rst` mid-frame aborts to IDLE on the next edge. No strobes are emitted for the aborted frame.
- Strobes are high for exactly one `clk` cycle: the cycle after the sample tick. `rx_bit` is valid in that cycle and holds until the next sample.
- Latency, counted in ticks from the detect tick (tick 0):
  - Start evaluation at tick OVERSAMPLE/2.
  - Data bit k sampled at OVERSAMPLE/2 + OVERSAMPLE·(k+1).
  - Stop sampled at OVERSAMPLE/2 + OVERSAMPLE·(DATA_WIDTH+P+1), where P = latched parity.
- 8N1 with `tick_16x` held high and detect in cycle 0:
  - first `shift_en` in cycle 25;
  - last `shift_en` in cycle 137;
  - `stop_chk_en`/`frame_done` in cycle 153.
- `busy` rises the cycle after the detect tick. It falls together with the `frame_done` pulse, or with `false_start`.

## Structure
- Shared package/defines:
  - `DATA_WIDTH`;
  - `OVERSAMPLE`;
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits).
- One natural sub-module: `rx_bit_timer`. It holds `tick_cnt` and produces `mid_start` and `sample` qualifiers from `tick_16x`, a load/clear input and the half/full terminal counts. The FSM, `bit_cnt` and the output registers stay in `uart_rx_ctrl`.

## Test plan
- 8N1 frame 0xA5, tick held high, parity_en=0:
  - 8 `shift_en` pulses in cycles 25+16k, with `rx_bit` LSB-first 1,0,1,0,0,1,0,1;
  - `frame_done` in cycle 153;
  - `parity_chk_en` never asserted.
- 8E1 frame 0x3C, parity_en=1, tick every 4th cycle:
  - one `parity_chk_en` with `rx_bit`=0 after the 8th data bit;
  - `frame_done` at tick 168 (+1 cycle).
- Glitch: `rx_in` low for 3 ticks then high → `false_start` at tick 8, `busy` back to 0, no other strobes.
- Two back-to-back 8N1 frames, second start edge 8 ticks after the first's stop sample → two `frame_done` pulses, 16 data strobes, no `false_start`.
- `rst` asserted during data bit 4 → next cycle all outputs at reset values; a following clean frame completes normally.
- Toggle `parity_en` during DATA of a frame started with 0 → no `parity_chk_en`, frame length unchanged.
